// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory loader.
// Parses a framed byte stream and writes big-endian words to memory.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] asm_q, asm_d;
    logic [7:0]  csum_q, csum_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic        in_ready_q, in_ready_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        accept;

    // Next-state: frame parsing, word assembly and registered outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        asm_d       = asm_q;
        csum_d      = csum_q;
        byte_idx_d  = byte_idx_q;
        word_idx_d  = word_idx_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        accept      = in_valid && in_ready_q;

        if (accept) begin
            case (state_q)
                S_CNT_HI: begin
                    cnt_d   = {in_data, cnt_q[7:0]};
                    state_d = S_CNT_LO;
                end
                S_CNT_LO: begin
                    cnt_d = {cnt_q[15:8], in_data};
                    if ({16'h0000, cnt_d} > MAX_W) begin
                        state_d = S_ERR;
                    end else if (cnt_d == 16'h0000) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    asm_d      = {asm_q[23:0], in_data};
                    csum_d     = csum_q ^ in_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = BASE_ADDR
                                    + {14'b0, word_idx_q, 2'b00};
                        mem_wdata_d = asm_d;
                        word_idx_d  = word_idx_q + 16'd1;
                        if (word_idx_d == cnt_q) begin
                            state_d = S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    state_d = (in_data == csum_q) ? S_DONE : S_ERR;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        in_ready_d = (state_d != S_DONE) && (state_d != S_ERR);
        cpu_hold_d = (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERR);
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_CNT_HI;
            cnt_q       <= 16'h0000;
            asm_q       <= 32'h0;
            csum_q      <= 8'h00;
            byte_idx_q  <= 2'd0;
            word_idx_q  <= 16'h0000;
            in_ready_q  <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= 32'h0;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            asm_q       <= asm_d;
            csum_q      <= csum_d;
            byte_idx_q  <= byte_idx_d;
            word_idx_q  <= word_idx_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader.
// u0 uses BASE_ADDR 0, u1 uses 0xFFFF_FFFC to exercise address wrap.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;

    logic        rdy0, we0, hold0, done0, err0;
    logic [31:0] addr0, wd0;
    logic        rdy1, we1, hold1, done1, err1;
    logic [31:0] addr1, wd1;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         q0[$];
    wr_t         q1[$];
    int          wcyc[$];
    logic [31:0] frame_words[$];
    logic        prev_we = 1'b0;

    imem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(256)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0),
        .cpu_hold(hold0), .done(done0), .error(err0)
    );

    imem_loader #(.BASE_ADDR(32'hFFFF_FFFC), .MAX_WORDS(256)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1),
        .cpu_hold(hold1), .done(done1), .error(err1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    // Write monitor: pops scoreboard entries as the DUTs write
    always @(negedge clk) begin
        wr_t e;
        if (!rst_n) begin
            prev_we = 1'b0;
        end else begin
            vecs++;
            if (we0 !== we1) begin
                errs++;
                $display("FAIL we_match: u0=%b u1=%b", we0, we1);
            end
            if (we0 === 1'b1) begin
                wcyc.push_back(cyc);
                vecs++;
                if (prev_we) begin
                    errs++;
                    $display("FAIL write_spacing: got back-to-back writes, need gap");
                end
                vecs++;
                if (q0.size() == 0) begin
                    errs++;
                    $display("FAIL u0_unexpected_write: addr=%h data=%h, need none",
                             addr0, wd0);
                end else begin
                    e = q0.pop_front();
                    if (addr0 !== e.addr || wd0 !== e.data) begin
                        errs++;
                        $display("FAIL u0_write: got %h/%h need %h/%h",
                                 addr0, wd0, e.addr, e.data);
                    end
                end
            end
            if (we1 === 1'b1) begin
                vecs++;
                if (q1.size() == 0) begin
                    errs++;
                    $display("FAIL u1_unexpected_write: addr=%h data=%h, need none",
                             addr1, wd1);
                end else begin
                    e = q1.pop_front();
                    if (addr1 !== e.addr || wd1 !== e.data) begin
                        errs++;
                        $display("FAIL u1_write: got %h/%h need %h/%h",
                                 addr1, wd1, e.addr, e.data);
                    end
                end
            end
            prev_we = we0;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive one byte from a negedge; sample just after its edge
    task automatic send_byte(input logic [7:0] b, input int gap,
                             output logic rdy_s, output logic we_s);
        in_valid = 1'b1;
        in_data  = b;
        rdy_s    = rdy0;
        @(posedge clk);
        @(negedge clk);
        we_s     = we0;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input logic [15:0] cnt, input logic [7:0] csum,
                              input int gap);
        logic        r, w;
        logic [31:0] wd;
        send_byte(cnt[15:8], gap, r, w);
        send_byte(cnt[7:0], gap, r, w);
        for (int i = 0; i < int'(cnt); i++) begin
            wd = frame_words[i];
            q0.push_back({32'(i * 4), wd});
            q1.push_back({32'hFFFF_FFFC + 32'(i * 4), wd});
            for (int k = 3; k >= 0; k--) begin
                send_byte(wd[k*8 +: 8], (k == 0) ? gap : gap, r, w);
                vecs++;
                if (r !== 1'b1) begin
                    errs++;
                    $display("FAIL data_ready: word %0d byte %0d in_ready=%b need 1",
                             i, k, r);
                end
                vecs++;
                if (w !== (k == 0)) begin
                    errs++;
                    $display("FAIL write_timing: word %0d byte %0d mem_we=%b need %b",
                             i, k, w, (k == 0));
                end
            end
        end
        send_byte(csum, 0, r, w);
    endtask

    task automatic test_reset();
        do_reset();
        vecs++;
        if (rdy0 !== 1'b1 || we0 !== 1'b0 || addr0 !== 32'h0 || wd0 !== 32'h0 ||
            hold0 !== 1'b1 || done0 !== 1'b0 || err0 !== 1'b0) begin
            errs++;
            $display("FAIL reset_u0: rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b, need 1 0 0 0 1 0 0",
                     rdy0, we0, addr0, wd0, hold0, done0, err0);
        end
        vecs++;
        if (addr1 !== 32'hFFFF_FFFC || rdy1 !== 1'b1 || hold1 !== 1'b1) begin
            errs++;
            $display("FAIL reset_u1: addr=%h rdy=%b hold=%b, need fffffffc 1 1",
                     addr1, rdy1, hold1);
        end
    endtask

    task automatic test_back_to_back();
        int start;
        do_reset();
        frame_words = '{32'h2002_0005, 32'h0000_0000};
        wcyc.delete();
        start = cyc;
        send_frame(16'd2, 8'h27, 0);
        vecs++;
        if (wcyc.size() != 2) begin
            errs++;
            $display("FAIL b2b_write_count: got %0d need 2", wcyc.size());
        end else if (wcyc[0] != start + 6 || wcyc[1] != start + 10) begin
            errs++;
            $display("FAIL b2b_write_cycles: got %0d,%0d need 7,11",
                     wcyc[0] - start + 1, wcyc[1] - start + 1);
        end
        vecs++;
        if (cyc != start + 11 || done0 !== 1'b1 || hold0 !== 1'b0 ||
            rdy0 !== 1'b0 || err0 !== 1'b0) begin
            errs++;
            $display("FAIL b2b_done: cyc=%0d done=%b hold=%b rdy=%b err=%b, need 12 1 0 0 0",
                     cyc - start + 1, done0, hold0, rdy0, err0);
        end
    endtask

    task automatic test_gaps();
        do_reset();
        frame_words = '{32'h2002_0005, 32'h0000_0000};
        wcyc.delete();
        send_frame(16'd2, 8'h27, 2);
        vecs++;
        if (wcyc.size() != 2 || addr0 !== 32'h4 || wd0 !== 32'h0) begin
            errs++;
            $display("FAIL gap_writes: n=%0d addr=%h wd=%h need 2 4 0",
                     wcyc.size(), addr0, wd0);
        end
        vecs++;
        if (done0 !== 1'b1 || hold0 !== 1'b0 || err0 !== 1'b0) begin
            errs++;
            $display("FAIL gap_done: done=%b hold=%b err=%b need 1 0 0",
                     done0, hold0, err0);
        end
    endtask

    task automatic test_oversize();
        logic r, w;
        do_reset();
        wcyc.delete();
        send_byte(8'h01, 0, r, w);
        send_byte(8'h01, 0, r, w);
        vecs++;
        if (err0 !== 1'b1 || rdy0 !== 1'b0 || hold0 !== 1'b1 ||
            done0 !== 1'b0 || err1 !== 1'b1) begin
            errs++;
            $display("FAIL oversize: err=%b rdy=%b hold=%b done=%b err1=%b need 1 0 1 0 1",
                     err0, rdy0, hold0, done0, err1);
        end
        for (int i = 0; i < 8; i++) send_byte(8'(i + 1), 0, r, w);
        vecs++;
        if (wcyc.size() != 0 || err0 !== 1'b1 || hold0 !== 1'b1) begin
            errs++;
            $display("FAIL oversize_after: writes=%0d err=%b hold=%b need 0 1 1",
                     wcyc.size(), err0, hold0);
        end
    endtask

    task automatic test_bad_csum();
        logic r, w;
        do_reset();
        frame_words = '{32'hDEAD_BEEF};
        wcyc.delete();
        send_frame(16'd1, 8'h00, 0);
        vecs++;
        if (err0 !== 1'b1 || done0 !== 1'b0 || hold0 !== 1'b1 || rdy0 !== 1'b0) begin
            errs++;
            $display("FAIL bad_csum: err=%b done=%b hold=%b rdy=%b need 1 0 1 0",
                     err0, done0, hold0, rdy0);
        end
        for (int i = 0; i < 6; i++) send_byte(8'h22, 0, r, w);
        vecs++;
        if (wcyc.size() != 1 || err0 !== 1'b1 || done0 !== 1'b0) begin
            errs++;
            $display("FAIL bad_csum_after: writes=%0d err=%b done=%b need 1 1 0",
                     wcyc.size(), err0, done0);
        end
    endtask

    task automatic test_zero_count();
        do_reset();
        wcyc.delete();
        send_frame(16'd0, 8'h00, 0);
        vecs++;
        if (done0 !== 1'b1 || hold0 !== 1'b0 || err0 !== 1'b0 || wcyc.size() != 0) begin
            errs++;
            $display("FAIL zero_count: done=%b hold=%b err=%b writes=%0d need 1 0 0 0",
                     done0, hold0, err0, wcyc.size());
        end
    endtask

    task automatic test_wrap();
        do_reset();
        frame_words = '{32'h0102_0304, 32'hA0B0_C0D0};
        send_frame(16'd2, 8'h04, 1);
        vecs++;
        if (addr1 !== 32'h0000_0000 || addr0 !== 32'h0000_0004 ||
            wd1 !== 32'hA0B0_C0D0 || done1 !== 1'b1) begin
            errs++;
            $display("FAIL wrap: addr1=%h addr0=%h wd1=%h done1=%b need 0 4 a0b0c0d0 1",
                     addr1, addr0, wd1, done1);
        end
    endtask

    task automatic test_mid_reset();
        logic r, w;
        do_reset();
        q0.push_back({32'h0, 32'h2002_0005});
        q1.push_back({32'hFFFF_FFFC, 32'h2002_0005});
        send_byte(8'h00, 0, r, w);
        send_byte(8'h02, 0, r, w);
        send_byte(8'h20, 0, r, w);
        send_byte(8'h02, 0, r, w);
        send_byte(8'h00, 0, r, w);
        send_byte(8'h05, 0, r, w);
        #2;
        rst_n = 1'b0;
        #1;
        vecs++;
        if (we0 !== 1'b0 || wd0 !== 32'h0 || addr1 !== 32'hFFFF_FFFC ||
            rdy0 !== 1'b1 || hold0 !== 1'b1 || done0 !== 1'b0) begin
            errs++;
            $display("FAIL async_reset: we=%b wd=%h addr1=%h rdy=%b hold=%b done=%b need 0 0 fffffffc 1 1 0",
                     we0, wd0, addr1, rdy0, hold0, done0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        frame_words = '{32'h1234_5678};
        send_frame(16'd1, 8'h08, 0);
        vecs++;
        if (addr0 !== 32'h0 || wd0 !== 32'h1234_5678 || done0 !== 1'b1 ||
            hold0 !== 1'b0) begin
            errs++;
            $display("FAIL post_reset_frame: addr=%h wd=%h done=%b hold=%b need 0 12345678 1 0",
                     addr0, wd0, done0, hold0);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_oversize();
        test_bad_csum();
        test_zero_count();
        test_wrap();
        test_mid_reset();
        repeat (2) @(negedge clk);
        vecs++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errs++;
            $display("FAIL scoreboard_drain: u0 left %0d, u1 left %0d, need 0",
                     q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
